// File: rtl/muldiv_pkg.sv
// Shared opcode, state and sizing constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int ITER_COUNT = MD_WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Purely combinational; acc is {upper(WIDTH+1), lower(WIDTH)}.
module muldiv_step import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               div_mode,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH:0]   acc_next,
  output logic               qbit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   rem_n;

  always_comb begin
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    rem_n    = '0;
    qbit     = 1'b0;
    acc_next = '0;
    if (div_mode) begin
      // Quotient bit lands in acc_next[0] via qbit; the FSM ORs it in.
      shifted  = acc[2*WIDTH-1:WIDTH-1];
      diff     = {1'b0, shifted} - {2'b00, operand};
      qbit     = ~diff[WIDTH+1];
      rem_n    = qbit ? diff[WIDTH:0] : shifted;
      acc_next = {rem_n, acc[WIDTH-2:0], 1'b0};
    end else begin
      sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);
      acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: MTHI/MTLO in one edge, mult/div in 33 busy cycles (result visible in cycle 34).
// Backpressure: stall holds any HI/LO writer or reader in decode while busy.
module hilo_muldiv_ctrl import muldiv_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_read,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   step_acc;
  logic               step_qbit;
  logic [WIDTH-1:0]   opd;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;

  logic               is_signed;
  logic               div_zero;
  logic [WIDTH-1:0]   a_cap;
  logic [WIDTH-1:0]   b_cap;
  logic               neg_q_in;
  logic               neg_r_in;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign busy  = (state != IDLE);
  assign stall = busy & (op_valid | hilo_read);

  // Divide by zero keeps the raw dividend and skips sign fix so hi returns a unchanged.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    div_zero  = ((op == OP_DIV) || (op == OP_DIVU)) && (b == '0);
    a_cap     = a;
    b_cap     = b;
    if (is_signed && !div_zero && a[WIDTH-1])
      a_cap = -a;
    if (is_signed && b[WIDTH-1])
      b_cap = -b;
    neg_q_in  = is_signed && !div_zero && (a[WIDTH-1] ^ b[WIDTH-1]);
    neg_r_in  = is_signed && !div_zero && a[WIDTH-1];
  end

  always_comb begin
    prod_fix = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (is_div),
    .acc      (acc),
    .operand  (opd),
    .acc_next (step_acc),
    .qbit     (step_qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      opd    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              OP_MULT, OP_MULTU: begin
                acc    <= {{(WIDTH+1){1'b0}}, b_cap};
                opd    <= a_cap;
                is_div <= 1'b0;
                neg_q  <= neg_q_in;
                neg_r  <= neg_r_in;
                count  <= '0;
                state  <= ITER;
              end
              OP_DIV, OP_DIVU: begin
                acc    <= {{(WIDTH+1){1'b0}}, a_cap};
                opd    <= b_cap;
                is_div <= 1'b1;
                neg_q  <= neg_q_in;
                neg_r  <= neg_r_in;
                count  <= '0;
                state  <= ITER;
              end
              default: ;
            endcase
          end
        end
        ITER: begin
          acc   <= step_acc | {{(2*WIDTH){1'b0}}, step_qbit};
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH-1))
            state <= FIX;
        end
        FIX: begin
          hi    <= is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo    <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed plus randomized bench for hilo_muldiv_ctrl against an arithmetic HI/LO model.
module tb_hilo_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hilo_read;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .hilo_read (hilo_read),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Architectural MIPS HI/LO semantics written as plain arithmetic.
  task automatic ref_model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                           inout logic [31:0] h, inout logic [31:0] l);
    longint          p;
    longint unsigned up;
    int              sa;
    int              sb;
    sa = av;
    sb = bv;
    case (o)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        h = p[63:32];
        l = p[31:0];
      end
      OP_MULTU: begin
        up = {32'd0, av} * {32'd0, bv};
        h  = up[63:32];
        l  = up[31:0];
      end
      OP_DIV: begin
        if (bv == 0) begin
          l = 32'hFFFF_FFFF; h = av;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'd0;
        end else begin
          l = sa / sb; h = sa % sb;
        end
      end
      OP_DIVU: begin
        if (bv == 0) begin
          l = 32'hFFFF_FFFF; h = av;
        end else begin
          l = av / bv; h = av % bv;
        end
      end
      OP_MTHI: h = av;
      OP_MTLO: l = av;
      default: ;
    endcase
  endtask

  // Enters in an idle cycle; for mult/div returns in cycle 34 so a following call is back-to-back.
  task automatic do_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv, input bit hold);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int busy_cnt;
    int stall_cnt;
    bit held;
    bit done_seen;
    old_hi = exp_hi;
    old_lo = exp_lo;
    op_valid = 1'b1; op = o; a = av; b = bv; hilo_read = 1'b0;
    #1;
    chk("accept_stall", {63'd0, stall}, 64'd0);
    ref_model(o, av, bv, exp_hi, exp_lo);
    tick();
    if (o == OP_MTHI || o == OP_MTLO) begin
      op_valid = 1'b0; hilo_read = 1'b1;
      #1;
      chk("mt_hi", {32'd0, hi}, {32'd0, exp_hi});
      chk("mt_lo", {32'd0, lo}, {32'd0, exp_lo});
      chk("mt_busy_stall_done", {61'd0, busy, stall, done}, 64'd0);
      hilo_read = 1'b0;
    end else begin
      op_valid = hold; hilo_read = hold; op = OP_DIVU;
      busy_cnt = 0; stall_cnt = 0; held = 1'b1; done_seen = 1'b0;
      for (int i = 1; i <= 33; i++) begin
        a = $urandom; b = $urandom;
        #1;
        if (busy) busy_cnt++;
        if (stall) stall_cnt++;
        if (hi !== old_hi || lo !== old_lo) held = 1'b0;
        if (done) done_seen = 1'b1;
        tick();
      end
      #1;
      chk("busy_cycles", 64'(busy_cnt), 64'd33);
      chk("hilo_held", {63'd0, held}, 64'd1);
      chk("early_done", {63'd0, done_seen}, 64'd0);
      chk("done_c34", {63'd0, done}, 64'd1);
      chk("busy_c34", {63'd0, busy}, 64'd0);
      chk("stall_c34", {63'd0, stall}, 64'd0);
      chk("res_hi", {32'd0, hi}, {32'd0, exp_hi});
      chk("res_lo", {32'd0, lo}, {32'd0, exp_lo});
      if (hold) chk("stall_cycles", 64'(stall_cnt), 64'd33);
      op_valid = 1'b0; hilo_read = 1'b0;
    end
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          done_cnt;

    reset = 1'b1; op_valid = 1'b0; op = '0; a = '0; b = '0; hilo_read = 1'b0;
    repeat (2) tick();
    op_valid = 1'b1; hilo_read = 1'b1;
    #1;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy_done_stall", {61'd0, busy, done, stall}, 64'd0);
    op_valid = 1'b0; hilo_read = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_hi_lit", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo_lit", {32'd0, lo}, 64'h0000_0000_0000_0001);
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    chk("mult_lo_lit", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_hi_lit", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    do_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
    chk("divu_lo_lit", {32'd0, lo}, 64'd14);
    do_op(OP_DIVU, 32'h1234_5678, 32'd0, 1'b0);
    do_op(OP_DIV, 32'h1234_5678, 32'd0, 1'b0);
    chk("divz_hi_lit", {32'd0, hi}, 64'h0000_0000_1234_5678);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("ovf_lo_lit", {32'd0, lo}, 64'h0000_0000_8000_0000);
    do_op(OP_MULT, 32'd5, 32'hFFFF_FFFA, 1'b1);
    do_op(OP_DIVU, 32'd1000, 32'd10, 1'b0);

    // Reset in the middle of a divide after an MTLO.
    do_op(OP_MTLO, 32'h55, 32'd0, 1'b0);
    op_valid = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd3;
    tick();
    op_valid = 1'b0;
    repeat (14) tick();
    reset = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0;
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    tick();
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) done_cnt++;
      tick();
    end
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_idle", {63'd0, busy}, 64'd0);
    do_op(OP_MTHI, 32'hA5, 32'd0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      ro = 3'($urandom_range(0, 5));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
